// File: rtl/gpio_scan_sequencer.sv
// ---------------------------------------------------------------------------
// gpio_scan_sequencer
//
// Purpose:
//   Upstream driver for the GPIO one-hot decoder. A start request
//   validates a pin range [first_pin..last_pin]. If the range is good,
//   the block steps a 1-based pin index across it. Each index is held
//   for dwell+1 clock cycles. In one-shot mode the scan ends with a
//   single-cycle done pulse. In continuous mode it wraps from last back
//   to first until stop is asserted. A start with a bad range is
//   rejected with a single-cycle err pulse.
//
//   sel feeds the decoder's index input directly:
//     0     -> no pin selected
//     1..N  -> GPIO bit 0..N-1
//
// Parameters:
//   NUM_PINS  highest legal pin index
//   IDX_W     index width (2**IDX_W must exceed NUM_PINS)
//   DWELL_W   width of the dwell configuration and the dwell counter
//
// Ports:
//   clk         in   system clock, rising edge
//   nrst        in   asynchronous active-low reset
//   start       in   single-cycle scan request, sampled only while idle
//   stop        in   abort request, level-sampled every cycle
//   continuous  in   1 = wrap forever, 0 = one-shot (latched at start)
//   first_pin   in   first pin index, 1-based (latched at start)
//   last_pin    in   last pin index, 1-based (latched at start)
//   dwell       in   extra hold cycles per pin (latched at start)
//   sel         out  current pin index, 0 when not scanning
//   busy        out  high while a scan is running
//   done        out  one-cycle pulse when a one-shot scan completes
//   err         out  one-cycle pulse when a start is rejected
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module gpio_scan_sequencer #(
    parameter int NUM_PINS = 34,
    parameter int IDX_W    = 6,
    parameter int DWELL_W  = 16
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [IDX_W-1:0]   first_pin,
    input  logic [IDX_W-1:0]   last_pin,
    input  logic [DWELL_W-1:0] dwell,
    output logic [IDX_W-1:0]   sel,
    output logic               busy,
    output logic               done,
    output logic               err
);

    // Highest legal index, sized to the index width so that the range
    // check compares operands of equal width.
    localparam logic [IDX_W-1:0] MAX_PIN = IDX_W'(NUM_PINS);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;

    // Configuration captured when a start is accepted. The inputs may
    // change freely while a scan runs without affecting it.
    logic [IDX_W-1:0]     first_q, first_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 cont_q, cont_d;

    logic                 cfg_valid;
    logic                 dwell_expired;
    logic                 at_last;

    // A pin range is usable only when it is non-empty, starts at 1 or
    // above (0 means "no pin" to the decoder) and stays within the pins
    // that exist.
    always_comb begin
        cfg_valid = (first_pin != '0)
                 && (first_pin <= last_pin)
                 && (last_pin <= MAX_PIN);
    end

    // The dwell counter runs 0..dwell_q. The compare uses the full
    // counter width, so the largest dwell value is safe to use.
    always_comb begin
        dwell_expired = (cnt_q == dwell_q);
        at_last       = (sel_q == last_q);
    end

    // Next-state and next-output logic. Every _d signal defaults to its
    // current value, and done/err default low, so both pulses last a
    // single cycle without any extra logic.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        first_d = first_q;
        last_d  = last_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;

        unique case (state_q)
            IDLE: begin
                sel_d  = '0;
                busy_d = 1'b0;
                cnt_d  = '0;
                // When start and stop arrive together, the request is
                // dropped silently: neither a scan nor an err pulse.
                if (start && !stop) begin
                    if (cfg_valid) begin
                        first_d = first_pin;
                        last_d  = last_pin;
                        dwell_d = dwell;
                        cont_d  = continuous;
                        sel_d   = first_pin;
                        busy_d  = 1'b1;
                        state_d = SCAN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            SCAN: begin
                // Stop wins over both advance and wrap. Aborting a scan
                // never raises done.
                if (stop) begin
                    sel_d   = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (!dwell_expired) begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end else begin
                    cnt_d = '0;
                    if (!at_last) begin
                        // sel never passes last_q, and last_q is at most
                        // NUM_PINS, so this increment cannot overflow.
                        sel_d = sel_q + IDX_W'(1);
                    end else if (cont_q) begin
                        sel_d = first_q;
                    end else begin
                        sel_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                sel_d   = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, output and configuration registers. Reset clears every
    // register, including the latched configuration, so a reset in the
    // middle of a scan drops all outputs immediately.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            last_q  <= last_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
        end
    end

    assign sel  = sel_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_gpio_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gpio_scan_sequencer
//
// Directed testbench for gpio_scan_sequencer. Inputs change 1 ns after
// each rising edge. Outputs are checked at the same point, so each check
// sees the registered value for the cycle that just began.
// ---------------------------------------------------------------------------
module tb_gpio_scan_sequencer;

    localparam int IDX_W   = 6;
    localparam int DWELL_W = 16;

    logic               clk;
    logic               nrst;
    logic               start;
    logic               stop;
    logic               continuous;
    logic [IDX_W-1:0]   first_pin;
    logic [IDX_W-1:0]   last_pin;
    logic [DWELL_W-1:0] dwell;
    logic [IDX_W-1:0]   sel;
    logic               busy;
    logic               done;
    logic               err;

    int checkCount = 0;
    int passCount  = 0;

    gpio_scan_sequencer #(
        .NUM_PINS (34),
        .IDX_W    (IDX_W),
        .DWELL_W  (DWELL_W)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .first_pin  (first_pin),
        .last_pin   (last_pin),
        .dwell      (dwell),
        .sel        (sel),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // 10 ns free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Move to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        else
            passCount++;
    endtask

    task automatic checkAll(input string tag, input int expSel, input int expBusy,
                            input int expDone, input int expErr);
        checkOutput({tag, ".sel"},  32'(sel),  32'(expSel));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(expBusy));
        checkOutput({tag, ".done"}, 32'(done), 32'(expDone));
        checkOutput({tag, ".err"},  32'(err),  32'(expErr));
    endtask

    // Drive a configuration and pulse start for one edge. On return the
    // bench is in cycle T+1 of the request.
    task automatic applyStimulus(input int f, input int l, input int d, input logic c);
        first_pin  = IDX_W'(f);
        last_pin   = IDX_W'(l);
        dwell      = DWELL_W'(d);
        continuous = c;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // One-shot scan of pins 1..3 with dwell 2. Each pin is held 3 cycles,
    // and done appears at T+10. If disturb is set, start is pulsed and the
    // configuration inputs are changed mid-scan; neither may have any
    // effect.
    task automatic runOneShot(input string tag, input bit disturb);
        applyStimulus(1, 3, 2, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            checkAll($sformatf("%s.c%0d", tag, k), 1 + (k - 1) / 3, 1, 0, 0);
            if (disturb && k == 2) begin
                start      = 1'b1;
                first_pin  = IDX_W'(5);
                last_pin   = IDX_W'(20);
                dwell      = DWELL_W'(7);
                continuous = 1'b1;
            end
            if (disturb && k == 3) start = 1'b0;
            tick();
        end
        checkAll({tag, ".done"}, 0, 0, 1, 0);
    endtask

    initial begin
        nrst       = 1'b0;
        start      = 1'b1;
        stop       = 1'b0;
        continuous = 1'b0;
        first_pin  = IDX_W'(1);
        last_pin   = IDX_W'(3);
        dwell      = DWELL_W'(0);

        // Reset held with start high: everything must stay idle.
        tick();
        tick();
        checkAll("rst", 0, 0, 0, 0);
        start = 1'b0;
        nrst  = 1'b1;
        tick();
        tick();
        checkAll("idle", 0, 0, 0, 0);

        // Basic one-shot scan
        runOneShot("oneshot", 1'b0);
        tick();
        checkAll("oneshot.after", 0, 0, 0, 0);

        // Rejected configurations: pin 0, reversed range, last past 34
        applyStimulus(0, 3, 0, 1'b0);
        checkAll("bad0", 0, 0, 0, 1);
        tick();
        checkAll("bad0.after", 0, 0, 0, 0);
        applyStimulus(5, 4, 0, 1'b0);
        checkAll("badrev", 0, 0, 0, 1);
        tick();
        checkAll("badrev.after", 0, 0, 0, 0);
        applyStimulus(1, 35, 0, 1'b0);
        checkAll("bad35", 0, 0, 0, 1);
        tick();
        checkAll("bad35.after", 0, 0, 0, 0);

        // Top pin, single cycle
        applyStimulus(34, 34, 0, 1'b0);
        checkAll("pin34", 34, 1, 0, 0);
        tick();
        checkAll("pin34.done", 0, 0, 1, 0);
        tick();
        checkAll("pin34.after", 0, 0, 0, 0);

        // Continuous wrap, then stop
        applyStimulus(33, 34, 0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            checkAll($sformatf("wrap.c%0d", k), (k % 2 == 1) ? 33 : 34, 1, 0, 0);
            if (k == 5) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        checkAll("wrap.stop", 0, 0, 0, 0);
        tick();
        checkAll("wrap.stop2", 0, 0, 0, 0);

        // Ignored inputs during a scan. A new start is then issued in
        // the done cycle.
        runOneShot("ignore", 1'b1);
        applyStimulus(2, 2, 0, 1'b0);
        checkAll("restart", 2, 1, 0, 0);
        tick();
        checkAll("restart.done", 0, 0, 1, 0);
        tick();

        // Start together with stop while idle
        first_pin = IDX_W'(1);
        last_pin  = IDX_W'(3);
        start     = 1'b1;
        stop      = 1'b1;
        tick();
        start     = 1'b0;
        stop      = 1'b0;
        checkAll("startstop", 0, 0, 0, 0);
        tick();
        checkAll("startstop2", 0, 0, 0, 0);

        // Reset mid-scan at sel=2. It must take effect without a clock edge.
        applyStimulus(1, 3, 2, 1'b0);
        tick();
        tick();
        tick();
        checkAll("midrst.pre", 2, 1, 0, 0);
        #2 nrst = 1'b0;
        #1;
        checkAll("midrst.async", 0, 0, 0, 0);
        tick();
        tick();
        checkAll("midrst.held", 0, 0, 0, 0);
        nrst = 1'b1;
        tick();
        runOneShot("postrst", 1'b0);
        tick();
        checkAll("postrst.after", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/gpio_scan_sequencer.md
Name: gpio_scan_sequencer

Overview:
Upstream driver of the GPIO one-hot decoder. It steps a 1-based pin index across a programmable pin range, holding each index for a programmable dwell time. The block supports one-shot and continuous (wrap) modes. Its `sel` output feeds the decoder's 6-bit `in` directly: 0 means no pin selected, 1..34 select GPIO bits 0..33.

Parameters:
NUM_PINS, 34, highest legal pin index
IDX_W, 6, index width; must satisfy 2^IDX_W > NUM_PINS
DWELL_W, 16, width of dwell counter/config

Ports:
clk  in  1  system clock, rising edge
nrst  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a scan; sampled only in IDLE
stop  in  1  abort request; level-sampled each cycle
continuous  in  1  1 = wrap last->first forever, 0 = one-shot; latched at start
first_pin  in  IDX_W  first pin index (1-based); latched at start
last_pin  in  IDX_W  last pin index (1-based); latched at start
dwell  in  DWELL_W  extra hold cycles per pin; latched at start
sel  out  IDX_W  current pin index to decoder; 0 when not scanning
busy  out  1  high while scanning
done  out  1  one-cycle pulse at normal one-shot completion
err  out  1  one-cycle pulse when start is rejected for a bad config

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - `nrst` low asynchronously forces: state=IDLE, sel=0, busy=0, done=0, err=0, counters=0, latched config=0.
  - Release is synchronous to `clk`.
- All outputs are registered.
- States: IDLE, SCAN.
- IDLE:
  - sel=0, busy=0.
  - On a clock edge with start=1 and stop=0, validate the config:
    - Valid requires 1 <= first_pin <= last_pin <= NUM_PINS.
    - Invalid: err=1 for exactly the next cycle; remain IDLE; sel stays 0.
    - Valid: latch first_pin, last_pin, dwell, continuous; go to SCAN. In the next cycle sel=first_pin, busy=1, dwell counter=0.
  - start and stop high together in IDLE: start is ignored, no err.
- SCAN:
  - Each edge without stop: if dwell counter != latched dwell, increment the counter and hold sel. Otherwise clear the counter and advance.
  - Each pin is therefore held exactly dwell+1 cycles; dwell=0 means 1 cycle per pin.
  - Advance when sel != last: sel = sel+1.
  - Advance when sel == last and continuous=1: sel = first (wrap), busy stays 1, no done pulse.
  - Advance when sel == last and continuous=0: next cycle sel=0, busy=0, done=1 for one cycle, state=IDLE.
  - One-shot latency: start edge at cycle T, sel=first at T+1, done high at T+1+N*(dwell+1), where N=last-first+1.
  - stop=1 on any edge in SCAN: next cycle sel=0, busy=0, done=0, state=IDLE. Stop has priority over advance and wrap.
  - start during SCAN is ignored. Changes to first_pin/last_pin/dwell/continuous during SCAN have no effect.
- A new start is accepted in the cycle done is high (state is IDLE). The next scan's sel appears one cycle later; done and the new sel never overlap.
- sel is never outside {0} ∪ [first..last] of the latched range, so the decoder's out-of-range-to-zero path is never exercised by this block.
- Reset mid-scan: all outputs drop immediately (asynchronous). No done or err is produced.
- Width rules: sel increments only up to latched last (<= NUM_PINS), so no overflow. Dwell compare is full DWELL_W; dwell = 2^DWELL_W-1 is legal.

Test Plan:
- Reset: hold nrst=0 with start=1 -> sel=0, busy=0, done=0, err=0. Release; no activity until a start is sampled.
- One-shot: first=1, last=3, dwell=2, continuous=0, start at T -> sel=1 for T+1..T+3, 2 for T+4..T+6, 3 for T+7..T+9; at T+10 sel=0, busy=0, done=1; at T+11 done=0.
- Bad config: first=0/last=3 -> err=1 one cycle, sel stays 0. first=5/last=4 -> err. last=35 -> err. first=last=34, dwell=0 -> sel=34 for one cycle, then done.
- Continuous wrap: first=33, last=34, dwell=0, continuous=1 -> sel sequence 33,34,33,34,... with busy=1 and no done. Assert stop after 5 cycles -> next cycle sel=0, busy=0, no done.
- Ignored inputs: during the one-shot scan, pulse start and change first_pin/dwell -> sequence identical to the one-shot case. Start together with stop in IDLE -> no scan, no err.
- Reset mid-scan: drive nrst low at sel=2 -> sel=0 and busy=0 immediately, without a clock edge. After release, a new start behaves per the one-shot case.
